// File: rtl/wb_pkg.sv
// Shared Wishbone definitions used by the bus arbiter and the slave address decoder.
package wb_pkg;

    // Default bus geometry; the address decoder uses the same widths.
    localparam int unsigned WB_AW = 16;
    localparam int unsigned WB_DW = 16;

    // Arbiter FSM encoding.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StOwn   = 2'd1,
        StDrain = 2'd2
    } wb_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first requester at or above the
// pointer (wrapping), plus the pointer value that follows that winner.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] ptr_o
);

    // Walk offsets from farthest to nearest so the nearest requester is assigned last and wins.
    always_comb begin
        gnt_o = '0;
        ptr_o = ptr_i;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr_i) + k;
            if (idx >= int'(N)) begin
                idx = idx - int'(N);
            end
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
                ptr_o      = (idx == int'(N) - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone arbiter: shares one slave-side bus between NUM_MASTERS masters and
// terminates unacknowledged strobes with an error after TIMEOUT_CYCLES cycles.
module wb_bus_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS           = 4,
    parameter int unsigned WISHBONE_ADDRESSWIDTH = WB_AW,
    parameter int unsigned DATAWIDTH             = WB_DW,
    parameter int unsigned TIMEOUT_CYCLES        = 255
) (
    input  logic                                       CLK_I,
    input  logic                                       RST_I,
    input  logic [NUM_MASTERS-1:0]                     M_CYC_I,
    input  logic [NUM_MASTERS-1:0]                     M_STB_I,
    input  logic [NUM_MASTERS-1:0]                     M_WE_I,
    input  logic [NUM_MASTERS*WISHBONE_ADDRESSWIDTH-1:0] M_ADR_I,
    input  logic [NUM_MASTERS*DATAWIDTH-1:0]           M_DAT_I,
    output logic [DATAWIDTH-1:0]                       M_DAT_O,
    output logic [NUM_MASTERS-1:0]                     M_ACK_O,
    output logic [NUM_MASTERS-1:0]                     M_ERR_O,
    output logic                                       S_CYC_O,
    output logic                                       S_STB_O,
    output logic                                       S_WE_O,
    output logic [WISHBONE_ADDRESSWIDTH-1:0]           S_ADR_O,
    output logic [DATAWIDTH-1:0]                       S_DAT_O,
    input  logic [DATAWIDTH-1:0]                       S_DAT_I,
    input  logic                                       S_ACK_I,
    output logic [NUM_MASTERS-1:0]                     GNT_O,
    output logic                                       TMO_O
);

    localparam int unsigned N  = NUM_MASTERS;
    localparam int unsigned AW = WISHBONE_ADDRESSWIDTH;
    localparam int unsigned DW = DATAWIDTH;
    localparam int unsigned PW = $clog2(NUM_MASTERS);
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WdogLast = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [WW-1:0] WdogMax  = WW'(TIMEOUT_CYCLES);

    wb_arb_state_e state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [WW-1:0] wdog_q, wdog_d;

    logic [N-1:0]  rr_gnt;
    logic [PW-1:0] rr_ptr;
    logic          own_cyc, own_stb, own_we, owning, expire;
    logic [AW-1:0] own_adr;
    logic [DW-1:0] own_dat;

    rr_arbiter #(
        .N  (N),
        .PW (PW)
    ) u_rr (
        .req_i (M_CYC_I),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt),
        .ptr_o (rr_ptr)
    );

    // Mux the granted master's address and data; an all-zero grant drives zeros.
    always_comb begin
        own_adr = '0;
        own_dat = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (gnt_q[i]) begin
                own_adr = M_ADR_I[i*AW +: AW];
                own_dat = M_DAT_I[i*DW +: DW];
            end
        end
    end

    assign own_cyc = |(M_CYC_I & gnt_q);
    assign own_stb = |(M_STB_I & gnt_q);
    assign own_we  = |(M_WE_I & gnt_q);
    assign owning  = (state_q == StOwn);

    // DRAIN keeps the grant but hides the owner from the slave.
    assign S_CYC_O = owning & own_cyc;
    assign S_STB_O = S_CYC_O & own_stb;
    assign S_WE_O  = S_CYC_O & own_we;
    assign S_ADR_O = own_adr;
    assign S_DAT_O = own_dat;

    // An ACK in the expiry cycle wins over the timeout.
    assign expire  = S_STB_O & ~S_ACK_I & (wdog_q == WdogLast);
    assign M_ACK_O = (owning & S_ACK_I) ? gnt_q : '0;
    assign M_ERR_O = expire ? gnt_q : '0;
    assign TMO_O   = expire;
    assign GNT_O   = gnt_q;
    assign M_DAT_O = S_DAT_I;

    // Next-state for FSM, grant register, rr pointer and saturating watchdog.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        wdog_d  = '0;
        if (S_STB_O && !S_ACK_I) begin
            wdog_d = (wdog_q == WdogMax) ? wdog_q : wdog_q + WW'(1);
        end
        unique case (state_q)
            StIdle: begin
                if (|M_CYC_I) begin
                    gnt_d   = rr_gnt;
                    ptr_d   = rr_ptr;
                    state_d = StOwn;
                end
            end
            StOwn: begin
                if (!own_cyc) begin
                    gnt_d   = '0;
                    state_d = StIdle;
                end else if (expire) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!own_cyc) begin
                    gnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            ptr_q   <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            wdog_q  <= wdog_d;
        end
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter with randomized stimulus and a round-robin model.
module tb_wb_bus_arbiter;

    localparam int N   = 4;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int TMO = 255;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat;
    logic [DW-1:0]   m_dat_o;
    logic [N-1:0]    m_ack, m_err, gnt;
    logic            s_cyc, s_stb, s_we, s_ack, tmo;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_dat_o, s_dat_i;

    int n_cmp   = 0;
    int n_bad   = 0;
    int exp_ptr = 0;

    always #5 clk = ~clk;

    wb_bus_arbiter #(
        .NUM_MASTERS           (N),
        .WISHBONE_ADDRESSWIDTH (AW),
        .DATAWIDTH             (DW),
        .TIMEOUT_CYCLES        (TMO)
    ) dut (
        .CLK_I   (clk),
        .RST_I   (rst),
        .M_CYC_I (m_cyc),
        .M_STB_I (m_stb),
        .M_WE_I  (m_we),
        .M_ADR_I (m_adr),
        .M_DAT_I (m_dat),
        .M_DAT_O (m_dat_o),
        .M_ACK_O (m_ack),
        .M_ERR_O (m_err),
        .S_CYC_O (s_cyc),
        .S_STB_O (s_stb),
        .S_WE_O  (s_we),
        .S_ADR_O (s_adr),
        .S_DAT_O (s_dat_o),
        .S_DAT_I (s_dat_i),
        .S_ACK_I (s_ack),
        .GNT_O   (gnt),
        .TMO_O   (tmo)
    );

    // Winner = requester at the smallest rotated distance from the pointer.
    function automatic int ref_pick(input logic [N-1:0] req, input int ptr);
        int best;
        int bestd;
        best  = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                int d;
                d = (i - ptr + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_cyc   = '0;
        m_stb   = '0;
        m_we    = '0;
        m_adr   = '0;
        m_dat   = '0;
        s_ack   = 1'b0;
        s_dat_i = '0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        m_cyc   = N'($urandom);
        m_stb   = m_cyc;
        m_we    = N'($urandom);
        m_adr   = {$urandom, $urandom};
        m_dat   = {$urandom, $urandom};
        s_ack   = 1'b1;
        s_dat_i = DW'($urandom);
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_cmp++; if (gnt !== '0) begin n_bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
        n_cmp++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin
            n_bad++; $display("FAIL reset_ctrl got=%b want=000", {s_cyc, s_stb, s_we});
        end
        n_cmp++; if (s_adr !== '0 || s_dat_o !== '0) begin
            n_bad++; $display("FAIL reset_adr_dat got=%h/%h want=0/0", s_adr, s_dat_o);
        end
        n_cmp++; if (m_ack !== '0 || m_err !== '0 || tmo !== 1'b0) begin
            n_bad++; $display("FAIL reset_resp got=%b/%b/%b want=0", m_ack, m_err, tmo);
        end
        n_cmp++; if (m_dat_o !== s_dat_i) begin
            n_bad++; $display("FAIL reset_dat_bcast got=%h want=%h", m_dat_o, s_dat_i);
        end
        next_cycle();
        rst = 1'b0;
        clear_inputs();
        exp_ptr = 0;
        next_cycle();
    endtask

    task automatic test_single_transfer();
        int m, dly, acks;
        logic [N-1:0]  oh;
        logic [AW-1:0] adr;
        logic [DW-1:0] wdat, rdat;
        logic          we;
        for (int it = 0; it < 4; it++) begin
            m    = (it == 0) ? 0 : int'($urandom_range(0, N - 1));
            adr  = (it == 0) ? 16'h2004 : AW'($urandom);
            we   = (it == 0) ? 1'b0 : 1'($urandom);
            dly  = (it == 0) ? 3 : int'($urandom_range(0, 5));
            wdat = DW'($urandom);
            rdat = DW'($urandom);
            oh = '0; oh[m] = 1'b1;
            m_cyc = oh; m_stb = oh; m_we = we ? oh : '0;
            m_adr = {$urandom, $urandom}; m_adr[m*AW +: AW] = adr;
            m_dat = {$urandom, $urandom}; m_dat[m*DW +: DW] = wdat;
            @(negedge clk);
            n_cmp++; if (gnt !== '0) begin n_bad++; $display("FAIL single_gnt_latency got=%b want=0000", gnt); end
            next_cycle();
            acks = 0;
            for (int c = 0; c <= dly; c++) begin
                s_ack   = (c == dly);
                s_dat_i = rdat;
                @(negedge clk);
                if (c == 0) begin
                    n_cmp++; if (gnt !== oh) begin n_bad++; $display("FAIL single_gnt got=%b want=%b", gnt, oh); end
                    n_cmp++; if ({s_cyc, s_stb, s_we} !== {2'b11, we}) begin
                        n_bad++; $display("FAIL single_ctrl got=%b want=%b", {s_cyc, s_stb, s_we}, {2'b11, we});
                    end
                    n_cmp++; if (s_adr !== adr || s_dat_o !== wdat) begin
                        n_bad++; $display("FAIL single_mux got=%h/%h want=%h/%h", s_adr, s_dat_o, adr, wdat);
                    end
                end
                if (m_ack[m] === 1'b1) acks++;
                n_cmp++; if (m_ack !== ((c == dly) ? oh : '0)) begin
                    n_bad++; $display("FAIL single_ack_route c=%0d got=%b want=%b", c, m_ack, (c == dly) ? oh : '0);
                end
                if (c == dly) begin
                    n_cmp++; if (m_dat_o !== rdat) begin n_bad++; $display("FAIL single_rdata got=%h want=%h", m_dat_o, rdat); end
                end
                next_cycle();
            end
            s_ack = 1'b0; m_cyc = '0; m_stb = '0;
            @(negedge clk);
            n_cmp++; if (acks != 1) begin n_bad++; $display("FAIL single_ack_count got=%0d want=1", acks); end
            n_cmp++; if (gnt !== oh || s_cyc !== 1'b0) begin
                n_bad++; $display("FAIL single_release got=%b/%b want=%b/0", gnt, s_cyc, oh);
            end
            next_cycle();
            @(negedge clk);
            n_cmp++; if (gnt !== '0) begin n_bad++; $display("FAIL single_gnt_clear got=%b want=0000", gnt); end
            next_cycle();
            exp_ptr = (m + 1) % N;
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0]    mask, oh;
        logic [N*AW-1:0] adrs;
        int              w;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        exp_ptr = 0;
        for (int t = 0; t < 13; t++) begin
            if (t < 5) mask = '1;
            else       mask = N'($urandom_range(1, (1 << N) - 1));
            adrs  = {$urandom, $urandom};
            m_cyc = mask; m_stb = mask; m_adr = adrs; m_we = N'($urandom);
            @(negedge clk);
            n_cmp++; if (gnt !== '0 || s_cyc !== 1'b0) begin
                n_bad++; $display("FAIL rr_idle_gap t=%0d got=%b/%b want=0000/0", t, gnt, s_cyc);
            end
            w = ref_pick(mask, exp_ptr);
            oh = '0; oh[w] = 1'b1;
            next_cycle();
            s_ack = 1'b1; s_dat_i = DW'($urandom);
            @(negedge clk);
            n_cmp++; if (gnt !== oh) begin n_bad++; $display("FAIL rr_grant t=%0d got=%b want=%b", t, gnt, oh); end
            n_cmp++; if (s_adr !== adrs[w*AW +: AW]) begin
                n_bad++; $display("FAIL rr_adr_mux t=%0d got=%h want=%h", t, s_adr, adrs[w*AW +: AW]);
            end
            n_cmp++; if (m_ack !== oh) begin n_bad++; $display("FAIL rr_ack_route t=%0d got=%b want=%b", t, m_ack, oh); end
            next_cycle();
            s_ack = 1'b0; m_cyc[w] = 1'b0; m_stb[w] = 1'b0;
            @(negedge clk);
            n_cmp++; if (gnt !== oh || s_cyc !== 1'b0) begin
                n_bad++; $display("FAIL rr_release t=%0d got=%b/%b want=%b/0", t, gnt, s_cyc, oh);
            end
            exp_ptr = (w + 1) % N;
            next_cycle();
        end
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_timeout();
        int           m, first, pulses, misroute, stb_bad;
        logic [N-1:0] oh;
        for (int it = 0; it < 2; it++) begin
            m = (it == 0) ? 2 : int'($urandom_range(0, N - 1));
            oh = '0; oh[m] = 1'b1;
            m_cyc = oh; m_stb = oh; m_we = N'($urandom); m_adr = {$urandom, $urandom};
            m_adr[m*AW +: AW] = (it == 0) ? 16'h5000 : 16'h1000;
            s_ack = 1'b0;
            next_cycle();
            first = 0; pulses = 0; misroute = 0; stb_bad = 0;
            for (int k = 1; k <= TMO + 3; k++) begin
                @(negedge clk);
                if (tmo === 1'b1) begin
                    pulses++;
                    if (first == 0) first = k;
                end
                if (m_err !== ((tmo === 1'b1) ? oh : '0)) misroute++;
                if (k <= TMO && s_stb !== 1'b1) stb_bad++;
                if (k > TMO && (s_cyc !== 1'b0 || s_stb !== 1'b0)) stb_bad++;
                next_cycle();
            end
            n_cmp++; if (first != TMO) begin n_bad++; $display("FAIL tmo_cycle got=%0d want=%0d", first, TMO); end
            n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL tmo_pulses got=%0d want=1", pulses); end
            n_cmp++; if (misroute != 0) begin n_bad++; $display("FAIL tmo_err_route bad_cycles=%0d want=0", misroute); end
            n_cmp++; if (stb_bad != 0) begin n_bad++; $display("FAIL tmo_bus_drop bad_cycles=%0d want=0", stb_bad); end
            s_ack = 1'b1;
            @(negedge clk);
            n_cmp++; if (m_ack !== '0) begin n_bad++; $display("FAIL late_ack_ignored got=%b want=0000", m_ack); end
            n_cmp++; if (gnt !== oh) begin n_bad++; $display("FAIL drain_gnt_held got=%b want=%b", gnt, oh); end
            next_cycle();
            s_ack = 1'b0; m_cyc = '0; m_stb = '0;
            next_cycle();
            @(negedge clk);
            n_cmp++; if (gnt !== '0) begin n_bad++; $display("FAIL drain_release got=%b want=0000", gnt); end
            next_cycle();
            exp_ptr = (m + 1) % N;
        end
    endtask

    task automatic test_ack_at_expiry();
        int           m, early, first;
        logic [N-1:0] oh;
        m = int'($urandom_range(0, N - 1));
        oh = '0; oh[m] = 1'b1;
        m_cyc = oh; m_stb = oh; m_adr = {$urandom, $urandom};
        s_ack = 1'b0;
        next_cycle();
        early = 0;
        for (int k = 1; k <= TMO; k++) begin
            s_ack = (k == TMO);
            @(negedge clk);
            if (k == TMO) begin
                n_cmp++; if (m_ack !== oh) begin n_bad++; $display("FAIL expiry_ack got=%b want=%b", m_ack, oh); end
                n_cmp++; if (m_err !== '0 || tmo !== 1'b0) begin
                    n_bad++; $display("FAIL expiry_no_err got=%b/%b want=0000/0", m_err, tmo);
                end
            end else if (tmo !== 1'b0 || m_err !== '0) begin
                early++;
            end
            next_cycle();
        end
        n_cmp++; if (early != 0) begin n_bad++; $display("FAIL expiry_early_tmo got=%0d want=0", early); end
        s_ack = 1'b0;
        first = 0;
        for (int k = 1; k <= TMO + 1; k++) begin
            @(negedge clk);
            if (tmo === 1'b1 && first == 0) first = k;
            next_cycle();
        end
        n_cmp++; if (first != TMO) begin n_bad++; $display("FAIL wdog_cleared_by_ack got=%0d want=%0d", first, TMO); end
        m_cyc = '0; m_stb = '0;
        next_cycle();
        next_cycle();
        exp_ptr = (m + 1) % N;
    endtask

    task automatic test_reset_mid();
        m_cyc = 4'b0010; m_stb = 4'b0010; m_adr = {$urandom, $urandom};
        next_cycle();
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL rstmid_setup got=%b want=0010", gnt); end
        next_cycle();
        rst = 1'b1; s_ack = 1'b1; m_cyc = '1; m_stb = '1;
        next_cycle();
        @(negedge clk);
        n_cmp++; if (gnt !== '0 || {s_cyc, s_stb, s_we} !== 3'b000 || s_adr !== '0) begin
            n_bad++; $display("FAIL rstmid_bus got=%b/%b/%h want=0000/000/0", gnt, {s_cyc, s_stb, s_we}, s_adr);
        end
        n_cmp++; if (m_ack !== '0 || m_err !== '0 || tmo !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_resp got=%b/%b/%b want=0", m_ack, m_err, tmo);
        end
        next_cycle();
        rst = 1'b0; s_ack = 1'b0;
        exp_ptr = 0;
        next_cycle();
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL rstmid_ptr got=%b want=0001", gnt); end
        next_cycle();
        clear_inputs();
        next_cycle();
        exp_ptr = 1;
    endtask

    task automatic test_starvation();
        logic [N-1:0] mask, oh;
        int           w, others, won;
        for (int r = 0; r < 4; r++) begin
            others = 0; won = 0;
            for (int t = 0; t < 6 && won == 0; t++) begin
                mask = {1'b1, 3'($urandom)};
                m_cyc = mask; m_stb = mask;
                w = ref_pick(mask, exp_ptr);
                oh = '0; oh[w] = 1'b1;
                next_cycle();
                @(negedge clk);
                n_cmp++; if (gnt !== oh) begin n_bad++; $display("FAIL starve_grant r=%0d got=%b want=%b", r, gnt, oh); end
                if (gnt[N-1] === 1'b1) won = 1;
                else others++;
                next_cycle();
                m_cyc[w] = 1'b0; m_stb[w] = 1'b0;
                exp_ptr = (w + 1) % N;
                next_cycle();
            end
            n_cmp++; if (won != 1 || others > N - 1) begin
                n_bad++; $display("FAIL starve_bound r=%0d got won=%0d others=%0d want won=1 others<=%0d", r, won, others, N - 1);
            end
            clear_inputs();
            next_cycle();
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_transfer();
        test_round_robin();
        test_timeout();
        test_ack_at_expiry();
        test_reset_mid();
        test_starvation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL sim_time_limit got=expired want=finished");
        $fatal(1, "time limit");
    end

endmodule
